// File: rtl/imem_fetch_responder_pkg.sv
// imem_fetch_responder_pkg: shared widths, constants and FSM encoding for the instruction fetch responder
package imem_fetch_responder_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_DEFAULT = 32'h0000_0013;
  localparam logic ERR_FETCH = 1'b1;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 RAM, one write port and one read-first synchronous read port
module imem_array
  import imem_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // Only the read register resets; array contents survive reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: valid/ready instruction fetch responder with one-entry registered output
// and error decode for misaligned or out-of-range byte addresses.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH),
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_instr,
  output logic              rsp_err,
  output logic [WORD_W-1:0] rsp_addr,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  output logic [15:0]       fetch_cnt
);
  state_t state, state_nxt;
  logic accept, err;
  logic [WORD_W-1:0] rd_data;
  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept = req_valid & req_ready;
  // High address bits must be zero so the top of the 32-bit space cannot alias low words
  assign err = |req_addr[1:0] | |req_addr[WORD_W-1:AW+2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = FULL;
    else if (state == FULL && rsp_ready) state_nxt = EMPTY;
  end
  always_comb begin
    rsp_valid = (state == FULL);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
      rsp_addr <= '0;
    end else if (accept) begin
      rsp_err <= err ? ERR_FETCH : 1'b0;
      rsp_addr <= req_addr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_cnt <= '0;
    else if (accept && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
  end
  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .rst(rst),
    .we(ld_en),
    .waddr(ld_addr),
    .wdata(ld_data),
    .re(accept),
    .raddr(req_addr[AW+1:2]),
    .rdata(rd_data)
  );
  assign rsp_instr = rsp_err ? NOP_WORD : rd_data;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed scenario tests for imem_fetch_responder
module tb_imem_fetch_responder;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, ld_en = 0;
  logic [31:0] req_addr = 0, rsp_instr, rsp_addr, ld_data = 0;
  logic [7:0] ld_addr = 0;
  logic [15:0] fetch_cnt;
  int errors = 0, checks = 0;
  logic [15:0] exp_cnt;

  imem_fetch_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .rsp_addr(rsp_addr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    ld_en = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_instr !== 32'h0 || rsp_addr !== 32'h0 || fetch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset: valid=%b err=%b instr=%h addr=%h cnt=%h, required all zero", rsp_valid, rsp_err, rsp_instr, rsp_addr, fetch_cnt);
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    for (int i = 0; i < 4; i++) load(i[7:0], vals[i]);
    rsp_ready = 1; req_valid = 1; req_addr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) req_addr = 32'((i + 1) * 4); else req_valid = 0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== vals[i] || rsp_err !== 1'b0 || rsp_addr !== 32'(i * 4)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b instr=%h err=%b addr=%h, required 1 %h 0 %h", i, rsp_valid, rsp_instr, rsp_err, rsp_addr, vals[i], i * 4);
      end
    end
    exp_cnt = 4;
    checks++;
    if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d, required %0d", fetch_cnt, exp_cnt); end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_instr !== 32'h44 || rsp_addr !== 32'hC) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b instr=%h addr=%h, required 0 00000044 0000000c", rsp_valid, rsp_instr, rsp_addr);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 0; req_valid = 1; req_addr = 4;
    step();
    req_addr = 8;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_ready: ready=%b valid=%b, required 0 1", req_ready, rsp_valid); end
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h22 || rsp_addr !== 32'h4 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b instr=%h addr=%h ready=%b, required 1 00000022 00000004 0", rsp_valid, rsp_instr, rsp_addr, req_ready);
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b, required 1", req_ready); end
    step();
    req_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h33 || rsp_addr !== 32'h8) begin
      errors++;
      $display("FAIL bp_next: valid=%b instr=%h addr=%h, required 1 00000033 00000008", rsp_valid, rsp_instr, rsp_addr);
    end
    step();
    exp_cnt += 2;
    checks++;
    if (fetch_cnt !== exp_cnt || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_cnt: cnt=%0d valid=%b, required %0d 0", fetch_cnt, rsp_valid, exp_cnt); end
  endtask

  task automatic test_errors();
    logic [31:0] bad [3];
    bad[0] = 32'h2; bad[1] = 32'd1024; bad[2] = 32'hFFFF_FFFC;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = bad[i];
      step();
      req_valid = 0;
      exp_cnt++;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_instr !== 32'h13 || rsp_addr !== bad[i] || fetch_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL err[%h]: valid=%b err=%b instr=%h addr=%h cnt=%0d, required 1 1 00000013 %h %0d", bad[i], rsp_valid, rsp_err, rsp_instr, rsp_addr, fetch_cnt, bad[i], exp_cnt);
      end
      step();
    end
    req_valid = 1; req_addr = 32'h3FC;
    load(8'hFF, 32'hCAFE_F00D);
    step();
    req_valid = 0;
    exp_cnt++;
    checks++;
    if (rsp_err !== 1'b0 || rsp_instr !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL last_word: err=%b instr=%h, required 0 cafef00d", rsp_err, rsp_instr);
    end
    step();
  endtask

  task automatic test_collision();
    load(8'd5, 32'hAA);
    ld_en = 1; ld_addr = 5; ld_data = 32'hBB;
    req_valid = 1; req_addr = 20; rsp_ready = 1;
    step();
    ld_en = 0;
    checks++;
    if (rsp_instr !== 32'hAA) begin errors++; $display("FAIL collide_old: got %h, required 000000aa", rsp_instr); end
    step();
    req_valid = 0;
    checks++;
    if (rsp_instr !== 32'hBB || rsp_valid !== 1'b1) begin errors++; $display("FAIL collide_new: instr=%h valid=%b, required 000000bb 1", rsp_instr, rsp_valid); end
    step();
  endtask

  task automatic test_async_reset();
    rsp_ready = 0; req_valid = 1; req_addr = 0;
    step();
    req_valid = 0;
    #2 rst = 1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || fetch_cnt !== 16'h0 || rsp_instr !== 32'h0) begin
      errors++;
      $display("FAIL async_rst: valid=%b cnt=%0d instr=%h, required 0 0 00000000", rsp_valid, fetch_cnt, rsp_instr);
    end
    step();
    rst = 0;
    rsp_ready = 1;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL async_dropped: valid=%b, required 0", rsp_valid); end
    req_valid = 1; req_addr = 0;
    step();
    req_valid = 0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h11 || fetch_cnt !== 16'd1) begin
      errors++;
      $display("FAIL async_retained: valid=%b instr=%h cnt=%0d, required 1 00000011 1", rsp_valid, rsp_instr, fetch_cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    rsp_ready = 1; req_valid = 1; req_addr = 0;
    repeat (65533) @(posedge clk);
    #1;
    checks++;
    if (fetch_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near: got %h, required fffe", fetch_cnt); end
    repeat (3) @(posedge clk);
    #1;
    req_valid = 0;
    checks++;
    if (fetch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h, required ffff", fetch_cnt); end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_collision();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
